wots_chain_sched: RTL and testbench

//  Parametrised WOTS chain scheduler; successor to the single-engine public-key generator.

---
 rtl/wots_chain_sched.sv | 256 +++++++++++++++++++++++++
 tb/tb_wots_chain_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wots_chain_sched.sv
// WOTS chain scheduler: fetches each chain's start element and digit, then hands the chain to a
// free gen_chain engine or, for zero-length chains, writes the element straight back.
module wots_chain_slot #(
    parameter int KEY_LEN = 256,
    parameter int LOG_W   = 4,
    parameter int LOG_LEN = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_dispatch,
    input  logic               i_wr_ack,
    input  logic [KEY_LEN-1:0] i_data,
    input  logic [LOG_W-1:0]   i_s,
    input  logic [LOG_W-1:0]   i_e,
    input  logic [LOG_LEN-1:0] i_idx,
    input  logic               i_ch_done,
    input  logic [KEY_LEN-1:0] i_ch_data_out,
    output logic               o_free,
    output logic               o_busy,
    output logic               o_pend,
    output logic [KEY_LEN-1:0] o_res,
    output logic [LOG_LEN-1:0] o_res_idx,
    output logic [KEY_LEN-1:0] o_data,
    output logic [LOG_W-1:0]   o_s,
    output logic [LOG_W-1:0]   o_e,
    output logic [LOG_LEN-1:0] o_idx
);
    logic               r_busy, r_pend;
    logic [KEY_LEN-1:0] r_data, r_res;
    logic [LOG_W-1:0]   r_s, r_e;
    logic [LOG_LEN-1:0] r_idx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy <= 1'b0;
            r_pend <= 1'b0;
            r_data <= '0;
            r_res  <= '0;
            r_s    <= '0;
            r_e    <= '0;
            r_idx  <= '0;
        end else if (i_dispatch) begin
            r_busy <= 1'b1;
            r_data <= i_data;
            r_s    <= i_s;
            r_e    <= i_e;
            r_idx  <= i_idx;
        end else if (r_busy && i_ch_done) begin
            r_busy <= 1'b0;
            r_pend <= 1'b1;
            r_res  <= i_ch_data_out;
        end else if (i_wr_ack) begin
            r_pend <= 1'b0;
        end
    end

    // Before dispatch the engine sees the staged operands directly so they line up with ch_start.
    assign o_data    = r_busy ? r_data : i_data;
    assign o_s       = r_busy ? r_s : i_s;
    assign o_e       = r_busy ? r_e : i_e;
    assign o_idx     = r_busy ? r_idx : i_idx;
    assign o_free    = !r_busy && !r_pend;
    assign o_busy    = r_busy;
    assign o_pend    = r_pend;
    assign o_res     = r_res;
    assign o_res_idx = r_idx;
endmodule

module wots_chain_sched #(
    parameter int WOTS_W   = 16,
    parameter int WOTS_LEN = 67,
    parameter int KEY_LEN  = 256,
    parameter int NUM_CH   = 2,
    localparam int LOG_W   = $clog2(WOTS_W),
    localparam int LOG_LEN = $clog2(WOTS_LEN)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [1:0]                i_mode,
    input  logic [255:0]              i_hash_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_in_rd_en,
    output logic [LOG_LEN-1:0]        o_in_rd_addr,
    input  logic [KEY_LEN-1:0]        i_in_dout,
    input  logic [LOG_W-1:0]          i_digit_in,
    output logic                      o_out_wr_en,
    output logic [LOG_LEN-1:0]        o_out_wr_addr,
    output logic [KEY_LEN-1:0]        o_out_wr_data,
    output logic [NUM_CH-1:0]         o_ch_start,
    output logic [NUM_CH*KEY_LEN-1:0] o_ch_data,
    output logic [NUM_CH*LOG_W-1:0]   o_ch_start_step,
    output logic [NUM_CH*LOG_W-1:0]   o_ch_end_step,
    output logic [NUM_CH*256-1:0]     o_ch_hash_addr,
    input  logic [NUM_CH*KEY_LEN-1:0] i_ch_data_out,
    input  logic [NUM_CH-1:0]         i_ch_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DISPATCH, S_BYPASS, S_DRAIN} state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_mode;
    logic [255:0]         r_hash_addr, w_ha;
    logic [LOG_LEN-1:0]   r_idx;
    logic [KEY_LEN-1:0]   r_data, r_byp_data;
    logic [LOG_W-1:0]     r_s, r_e, w_s, w_e;
    logic                 r_byp_vld;
    logic [LOG_LEN-1:0]   r_byp_idx;

    logic [NUM_CH-1:0]    w_free, w_busy, w_pend, w_disp_oh, w_wr_oh;
    logic [NUM_CH-1:0][KEY_LEN-1:0] w_res, w_eng_data;
    logic [NUM_CH-1:0][LOG_LEN-1:0] w_res_idx, w_eng_idx;
    logic [NUM_CH-1:0][LOG_W-1:0]   w_eng_s, w_eng_e;
    logic                 w_dispatch, w_byp_load, w_byp_wr, w_last;

    // Lowest set bit: engine for dispatch, result for write-back.
    assign w_disp_oh = w_free & (~w_free + NUM_CH'(1));
    assign w_wr_oh   = w_pend & (~w_pend + NUM_CH'(1));
    assign w_last    = (r_idx == LOG_LEN'(WOTS_LEN - 1));

    for (genvar j = 0; j < NUM_CH; j++) begin : g_eng
        wots_chain_slot #(.KEY_LEN(KEY_LEN), .LOG_W(LOG_W), .LOG_LEN(LOG_LEN)) u_slot (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_dispatch    (w_dispatch & w_disp_oh[j]),
            .i_wr_ack      (w_wr_oh[j]),
            .i_data        (r_data),
            .i_s           (r_s),
            .i_e           (r_e),
            .i_idx         (r_idx),
            .i_ch_done     (i_ch_done[j]),
            .i_ch_data_out (i_ch_data_out[j*KEY_LEN +: KEY_LEN]),
            .o_free        (w_free[j]),
            .o_busy        (w_busy[j]),
            .o_pend        (w_pend[j]),
            .o_res         (w_res[j]),
            .o_res_idx     (w_res_idx[j]),
            .o_data        (w_eng_data[j]),
            .o_s           (w_eng_s[j]),
            .o_e           (w_eng_e[j]),
            .o_idx         (w_eng_idx[j])
        );
        assign o_ch_start[j]                       = w_dispatch & w_disp_oh[j];
        assign o_ch_data[j*KEY_LEN +: KEY_LEN]     = w_eng_data[j];
        assign o_ch_start_step[j*LOG_W +: LOG_W]   = w_eng_s[j];
        assign o_ch_end_step[j*LOG_W +: LOG_W]     = w_eng_e[j];
    end

    always_comb begin
        w_ha           = '0;
        o_ch_hash_addr = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_ha                        = r_hash_addr;
            w_ha[95:64]                 = 32'(w_eng_idx[j]);
            o_ch_hash_addr[j*256 +: 256] = w_ha;
        end
    end

    always_comb begin
        w_s = '0;
        w_e = LOG_W'(WOTS_W - 1);
        case (r_mode)
            2'd1:    w_e = i_digit_in;
            2'd2:    w_s = i_digit_in;
            default: ;
        endcase
    end

    // Engine results win over the bypass word; one write per cycle.
    always_comb begin
        o_out_wr_en   = 1'b0;
        o_out_wr_addr = '0;
        o_out_wr_data = '0;
        w_byp_wr      = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_wr_oh[j]) begin
                o_out_wr_en   = 1'b1;
                o_out_wr_addr = w_res_idx[j];
                o_out_wr_data = w_res[j];
            end
        end
        if (!(|w_pend) && r_byp_vld) begin
            o_out_wr_en   = 1'b1;
            o_out_wr_addr = r_byp_idx;
            o_out_wr_data = r_byp_data;
            w_byp_wr      = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_rd_en  = 1'b0;
        w_dispatch  = 1'b0;
        w_byp_load  = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_FETCH;
            S_FETCH:  if (|w_free) begin
                o_in_rd_en  = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD:   w_state_nxt = (w_s == w_e) ? S_BYPASS : S_DISPATCH;
            S_DISPATCH: begin
                w_dispatch  = 1'b1;
                w_state_nxt = w_last ? S_DRAIN : S_FETCH;
            end
            S_BYPASS: if (!r_byp_vld || w_byp_wr) begin
                w_byp_load  = 1'b1;
                w_state_nxt = w_last ? S_DRAIN : S_FETCH;
            end
            S_DRAIN:  if (!(|w_busy) && !(|w_pend) && !r_byp_vld) begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_hash_addr <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_s         <= '0;
            r_e         <= '0;
            r_byp_vld   <= 1'b0;
            r_byp_data  <= '0;
            r_byp_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_mode      <= i_mode;
                r_hash_addr <= i_hash_addr;
                r_idx       <= '0;
            end
            if (r_state == S_LOAD) begin
                r_data <= i_in_dout;
                r_s    <= w_s;
                r_e    <= w_e;
            end
            if (w_dispatch || w_byp_load) r_idx <= r_idx + LOG_LEN'(1);
            if (w_byp_load) begin
                r_byp_vld  <= 1'b1;
                r_byp_data <= r_data;
                r_byp_idx  <= r_idx;
            end else if (w_byp_wr) begin
                r_byp_vld <= 1'b0;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_in_rd_addr = r_idx;
endmodule

// File: tb/tb_wots_chain_sched.sv
// Directed bench for wots_chain_sched with behavioural memories and gen_chain engines.
module tb_wots_chain_sched;
    localparam int LEN = 67, KL = 256, NCH = 2, LW = 4, LL = 7;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, hold = 1'b0, clr = 1'b0;
    logic [1:0] mode = '0;
    logic [255:0] hash_addr = '0, HA;
    logic busy, done, in_rd_en, out_wr_en;
    logic [LL-1:0] in_rd_addr, out_wr_addr;
    logic [KL-1:0] in_dout, out_wr_data;
    logic [LW-1:0] digit_in;
    logic [NCH-1:0] ch_start, ch_done;
    logic [NCH*KL-1:0] ch_data, ch_dout;
    logic [NCH*LW-1:0] ch_ss, ch_es;
    logic [NCH*256-1:0] ch_ha;

    logic [KL-1:0] seed [128], mem_in [128], out_mem [128], kg_mem [128], sig [128];
    logic [LW-1:0] dig [128];
    int wr_cnt [128];
    int cyc = 0, tot_wr, done_cnt, st_cnt, n_chk = 0, n_fail = 0, k;
    int lg_addr [2], lg_cyc [2];
    logic [NCH-1:0] e_busy;
    int e_cnt [NCH];

    wots_chain_sched dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_hash_addr(hash_addr),
        .o_busy(busy), .o_done(done), .o_in_rd_en(in_rd_en), .o_in_rd_addr(in_rd_addr),
        .i_in_dout(in_dout), .i_digit_in(digit_in), .o_out_wr_en(out_wr_en),
        .o_out_wr_addr(out_wr_addr), .o_out_wr_data(out_wr_data), .o_ch_start(ch_start),
        .o_ch_data(ch_data), .o_ch_start_step(ch_ss), .o_ch_end_step(ch_es),
        .o_ch_hash_addr(ch_ha), .i_ch_data_out(ch_dout), .i_ch_done(ch_done)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] chain_f(input logic [255:0] x, input int s, input int e,
                                             input logic [255:0] a);
        logic [255:0] v;
        v = x;
        for (int i = s; i < e; i++) v = {v[254:0], v[255]} ^ a ^ 256'(i);
        return v;
    endfunction

    always @(posedge clk) if (in_rd_en) begin
        in_dout  <= mem_in[in_rd_addr];
        digit_in <= dig[in_rd_addr];
    end

    // Engine model: result is taken from the operands the DUT still presents at completion.
    always @(posedge clk) begin
        for (int j = 0; j < NCH; j++) begin
            ch_done[j] <= 1'b0;
            if (rst) e_busy[j] <= 1'b0;
            else if (ch_start[j]) begin
                e_busy[j] <= 1'b1;
                e_cnt[j]  <= int'(ch_es[j*LW +: LW]) - int'(ch_ss[j*LW +: LW]);
            end else if (e_busy[j]) begin
                if (e_cnt[j] > 0) e_cnt[j] <= e_cnt[j] - 1;
                else if (!hold) begin
                    ch_done[j] <= 1'b1;
                    e_busy[j]  <= 1'b0;
                    ch_dout[j*KL +: KL] <= chain_f(ch_data[j*KL +: KL], int'(ch_ss[j*LW +: LW]),
                                                   int'(ch_es[j*LW +: LW]), ch_ha[j*256 +: 256]);
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            tot_wr <= 0; done_cnt <= 0; st_cnt <= 0;
            for (int i = 0; i < 128; i++) wr_cnt[i] <= 0;
        end else begin
            if (out_wr_en) begin
                out_mem[out_wr_addr] <= out_wr_data;
                wr_cnt[out_wr_addr]  <= wr_cnt[out_wr_addr] + 1;
                if (tot_wr < 2) begin
                    lg_addr[tot_wr] <= int'(out_wr_addr);
                    lg_cyc[tot_wr]  <= cyc;
                end
                tot_wr <= tot_wr + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            st_cnt <= st_cnt + $countones(ch_start);
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_errs(input logic [1:0] m);
        int n = 0, s, e;
        logic [255:0] a;
        for (int i = 0; i < LEN; i++) begin
            a = HA;
            a[95:64] = 32'(i);
            s = 0; e = 15;
            if (m == 2'd1) e = int'(dig[i]);
            if (m == 2'd2) s = int'(dig[i]);
            if (wr_cnt[i] != 1 || out_mem[i] !== chain_f(mem_in[i], s, e, a)) n++;
        end
        return n;
    endfunction

    function automatic int kg_diff();
        int n = 0;
        for (int i = 0; i < LEN; i++) if (out_mem[i] !== kg_mem[i] || wr_cnt[i] != 1) n++;
        return n;
    endfunction

    function automatic int n_starts(input logic [1:0] m);
        int n = 0;
        for (int i = 0; i < LEN; i++)
            if (m == 2'd1 ? dig[i] != 0 : m == 2'd2 ? dig[i] != 15 : 1'b1) n++;
        return n;
    endfunction

    task automatic start_run(input logic [1:0] m);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        mode = m; hash_addr = HA; start = 1'b1;
        @(negedge clk); start = 1'b0;
        mode = ~m; hash_addr = ~HA;
    endtask

    task automatic finish_run(input string tag, input logic [1:0] m);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin @(negedge clk); n++; end
        @(negedge clk);
        chk({tag, "_done"}, 256'(done_cnt), 256'(1));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_mem"}, 256'(mem_errs(m)), 256'(0));
        chk({tag, "_starts"}, 256'(st_cnt), 256'(n_starts(m)));
    endtask

    initial begin
        HA = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 128; i++) begin
            for (int w = 0; w < 8; w++) seed[i][w*32 +: 32] = $urandom;
            mem_in[i] = seed[i];
            dig[i] = LW'($urandom_range(0, 15));
        end
        dig[0] = 4'd0; dig[1] = 4'd15;

        repeat (2) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_rd_en", 256'(in_rd_en), 256'(0));
        chk("rst_wr_en", 256'(out_wr_en), 256'(0));
        chk("rst_ch_start", 256'(ch_start), 256'(0));
        chk("rst_ch_ha", ch_ha[255:0], 256'(0));
        chk("rst_wr_data", out_wr_data, 256'(0));
        rst = 1'b0;

        // keygen with per-cycle checks of the first fetch and dispatch
        start_run(2'd0);
        chk("kg_fetch_en", 256'(in_rd_en), 256'(1));
        chk("kg_fetch_addr", 256'(in_rd_addr), 256'(0));
        @(negedge clk);
        chk("kg_load_nostart", 256'(ch_start), 256'(0));
        @(negedge clk);
        chk("kg_dispatch", 256'(ch_start), 256'(2'b01));
        chk("kg_disp_data", ch_data[255:0], seed[0]);
        chk("kg_disp_steps", 256'({ch_ss[3:0], ch_es[3:0]}), 256'(8'h0f));
        chk("kg_disp_ha", ch_ha[255:0], {HA[255:96], 32'd0, HA[63:0]});
        finish_run("keygen", 2'd0);
        for (int i = 0; i < LEN; i++) kg_mem[i] = out_mem[i];

        start_run(2'd3);
        finish_run("mode3", 2'd0);

        for (int i = 0; i < LEN; i++) dig[i] = 4'd0;
        start_run(2'd1);
        finish_run("sign0", 2'd1);

        for (int i = 2; i < LEN; i++) dig[i] = LW'($urandom_range(0, 15));
        dig[0] = 4'd0; dig[1] = 4'd15;
        start_run(2'd1);
        finish_run("sign", 2'd1);
        for (int i = 0; i < LEN; i++) begin sig[i] = out_mem[i]; mem_in[i] = sig[i]; end

        start_run(2'd2);
        finish_run("pkfs", 2'd2);
        chk("pkfs_eq_keygen", 256'(kg_diff()), 256'(0));

        for (int i = 0; i < LEN; i++) begin mem_in[i] = seed[i]; dig[i] = 4'd15; end
        start_run(2'd2);
        finish_run("pkfs15", 2'd2);

        for (int i = 0; i < LEN; i++) dig[i] = 4'd0;
        start_run(2'd2);
        finish_run("pkfs0", 2'd2);
        chk("pkfs0_eq_keygen", 256'(kg_diff()), 256'(0));

        // both engines complete on the same cycle
        hold = 1'b1;
        start_run(2'd0);
        repeat (40) @(negedge clk);
        chk("hold_nowrite", 256'(tot_wr), 256'(0));
        hold = 1'b0;
        finish_run("simul", 2'd0);
        chk("simul_first", 256'(lg_addr[0]), 256'(0));
        chk("simul_second", 256'(lg_addr[1]), 256'(1));
        chk("simul_gap", 256'(lg_cyc[1] - lg_cyc[0]), 256'(1));

        start_run(2'd0);
        repeat (100) @(negedge clk);
        mode = 2'd1; hash_addr = ~HA; start = 1'b1;
        @(negedge clk); start = 1'b0;
        finish_run("ignore_start", 2'd0);

        // reset while the 20th result is on the write port
        start_run(2'd0);
        k = 0;
        while (!(out_wr_en && tot_wr == 19) && k < 3000) begin @(negedge clk); k++; end
        chk("rst_reach20", 256'(tot_wr), 256'(19));
        rst = 1'b1;
        #1;
        chk("midrst_busy", 256'(busy), 256'(0));
        chk("midrst_wr_en", 256'(out_wr_en), 256'(0));
        @(negedge clk); rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrst_nodone", 256'(done_cnt), 256'(0));
        chk("midrst_idle", 256'(busy), 256'(0));
        chk("midrst_nowrite", 256'(tot_wr), 256'(19));

        start_run(2'd0);
        finish_run("restart", 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
